// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty encoding common to the generator and the capture block,
// plus the capture FSM state type.
package pwm_pkg;
    localparam int DUTY_W   = 7;
    localparam int DUTY_MAX = 100;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        DIV  = 2'd2
    } cap_state_e;
endpackage

// File: rtl/pwm_div.sv
// Restoring divider for duty = (hi*100 + per/2) / per (round half up), clamped to DUTY_MAX.
// done_o pulses exactly CNT_W+7 cycles after the cycle in which start_i is accepted.
module pwm_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] hi_i,
    input  logic [CNT_W-1:0] per_i,
    output logic             busy_o,
    output logic             done_o,
    output duty_t            duty_o
);
    localparam int NUM_W  = CNT_W + DUTY_W;
    localparam int ITER_W = $clog2(NUM_W);

    // Handshake: start_i is accepted only while busy_o is low; each accepted start yields one
    // done_o pulse with duty_o valid in that cycle, unless abort_i cancels the division first.

    logic [NUM_W-1:0]  num_full;
    logic [NUM_W-1:0]  num_q;
    logic [NUM_W-1:0]  quo_q;
    logic [CNT_W-1:0]  rem_q;
    logic [CNT_W-1:0]  div_q;
    logic [ITER_W-1:0] iter_q;
    logic [CNT_W:0]    first_step;
    logic [CNT_W:0]    next_step;
    logic              busy_q;
    logic              done_q;

    // One shift-subtract step: returns {quotient bit, new remainder}.
    function automatic logic [CNT_W:0] div_step(input logic [CNT_W-1:0] rem,
                                                input logic             b,
                                                input logic [CNT_W-1:0] d);
        logic [CNT_W:0] sh;
        logic [CNT_W:0] diff;
        sh   = {rem, b};
        diff = sh - {1'b0, d};
        if (sh >= {1'b0, d}) begin
            div_step = {1'b1, diff[CNT_W-1:0]};
        end else begin
            div_step = {1'b0, sh[CNT_W-1:0]};
        end
    endfunction

    assign num_full   = NUM_W'(hi_i) * NUM_W'(DUTY_MAX) + NUM_W'(per_i >> 1);
    // The first quotient bit is resolved in the start cycle to meet the fixed latency.
    assign first_step = div_step(CNT_W'(0), num_full[NUM_W-1], per_i);
    assign next_step  = div_step(rem_q, num_q[NUM_W-1], div_q);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            num_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                busy_q <= 1'b0;
            end else if (start_i && !busy_q) begin
                num_q  <= num_full << 1;
                rem_q  <= first_step[CNT_W-1:0];
                quo_q  <= NUM_W'(first_step[CNT_W]);
                div_q  <= per_i;
                iter_q <= ITER_W'(NUM_W - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                num_q  <= num_q << 1;
                rem_q  <= next_step[CNT_W-1:0];
                quo_q  <= {quo_q[NUM_W-2:0], next_step[CNT_W]};
                iter_q <= iter_q - ITER_W'(1);
                if (iter_q == ITER_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

    always_comb begin
        duty_o = quo_q[DUTY_W-1:0];
        if (quo_q > NUM_W'(DUTY_MAX)) begin
            duty_o = duty_t'(DUTY_MAX);
        end
    end
endmodule

// File: rtl/pwm_capture.sv
// Measures period and round-half-up duty cycle of an asynchronous PWM input; a constant level
// is reported as 0/100 every PERIOD_MAX cycles. Build option PWM_CAP_GLITCH_FILTER_EN adds a filter.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int  PERIOD_MAX  = 1_000_000,
    parameter int  SYNC_STAGES = 2,
    parameter int  FILT_LEN    = 3,
    localparam int CNT_W       = $clog2(PERIOD_MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             pwm_i,
    output duty_t            dutycycle_o,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             overrun_o,
    output cap_state_e       state_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD_MAX);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic                   s_pwm;
    logic                   s_pwm_d;
    logic                   rise;
    logic                   timeout;
    logic [CNT_W-1:0]       per_cnt;
    logic [CNT_W-1:0]       hi_cnt;
    logic [CNT_W-1:0]       per_q;
    cap_state_e             state_q;
    logic                   div_start;
    logic                   div_busy;
    logic                   div_done;
    duty_t                  div_duty;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
        end
    end

    assign s_sync = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam int FILT_W = $clog2(FILT_LEN + 1);

    logic [FILT_W-1:0] filt_cnt;
    logic              filt_q;

    // Follow s_sync only after it has differed from the filtered level for FILT_LEN cycles in a row.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            filt_q   <= 1'b0;
            filt_cnt <= '0;
        end else if (s_sync == filt_q) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_W'(FILT_LEN - 1)) begin
            filt_q   <= s_sync;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FILT_W'(1);
        end
    end

    assign s_pwm = filt_q;
`else
    logic unused_filt_len;
    assign unused_filt_len = (FILT_LEN > 0);
    assign s_pwm           = s_sync;
`endif

    assign rise    = s_pwm & ~s_pwm_d;
    assign timeout = (per_cnt >= CNT_MAX) && !rise;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s_pwm_d <= 1'b0;
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            s_pwm_d <= s_pwm;
            if (rise) begin
                per_cnt <= CNT_W'(1);
                hi_cnt  <= CNT_W'(1);
            end else if (timeout) begin
                // The timeout cycle opens the next window, so timeouts repeat every PERIOD_MAX.
                per_cnt <= CNT_W'(1);
                hi_cnt  <= '0;
            end else begin
                if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_W'(1);
                if (s_pwm && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + CNT_W'(1);
            end
        end
    end

    // An edge coinciding with divider done starts the next division instead of being dropped.
    assign div_start = rise && !div_busy &&
                       ((state_q == MEAS) || ((state_q == DIV) && div_done));

    pwm_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .start_i (div_start),
        .abort_i (timeout),
        .hi_i    (hi_cnt),
        .per_i   (per_cnt),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .duty_o  (div_duty)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            dutycycle_o <= '0;
            period_o    <= '0;
            valid_o     <= 1'b0;
            overrun_o   <= 1'b0;
            per_q       <= '0;
        end else begin
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
            if (div_start) per_q <= per_cnt;
            if (timeout) begin
                dutycycle_o <= s_pwm ? duty_t'(DUTY_MAX) : '0;
                period_o    <= '0;
                valid_o     <= 1'b1;
                state_q     <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (rise) state_q <= MEAS;
                    MEAS: if (div_start) state_q <= DIV;
                    DIV: begin
                        if (div_done) begin
                            dutycycle_o <= div_duty;
                            period_o    <= per_q;
                            valid_o     <= 1'b1;
                            if (!div_start) state_q <= MEAS;
                        end else if (rise) begin
                            overrun_o <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign state_o = state_q;
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator; feeds duty-cycle measurements to control logic.
- Samples an asynchronous PWM waveform and measures its period in clock cycles, rising edge to rising edge.
- Converts high time / period into an integer duty cycle of 0..100, the same encoding as the generator's 7-bit duty input.
- Reports a constant level as 0 or 100 after a timeout.

Parameters:
- PERIOD_MAX, 1_000_000: longest measurable period in clk_i cycles; also the constant-level timeout.
- SYNC_STAGES, 2: flops in the pwm_i synchronizer, minimum 2.
- FILT_LEN, 3: glitch-filter stability length in cycles; used only with PWM_CAP_GLITCH_FILTER_EN.

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- pwm_i  in  1  asynchronous PWM input.
- dutycycle_o  out  7  last measured duty, 0..100.
- period_o  out  CNT_W  last measured period in cycles; 0 after timeout. CNT_W = $clog2(PERIOD_MAX+1).
- valid_o  out  1  one-cycle pulse when dutycycle_o/period_o update.
- overrun_o  out  1  one-cycle pulse when a measurement is dropped.

Behaviour:
- One clock domain. Reset is asynchronous assert, synchronous release via normal flop behaviour.
- Reset values: dutycycle_o=0, period_o=0, valid_o=0, overrun_o=0, synchronizer flops=0, FSM=IDLE.
- Synchronize pwm_i through SYNC_STAGES flops to give s_pwm. Rising edge = s_pwm & ~s_pwm_d.
- Counters, both saturating at PERIOD_MAX:
  - per_cnt increments every cycle.
  - hi_cnt increments when s_pwm=1.
  - On a rising edge both clear and restart at 1 / s_pwm (the edge cycle is counted).
- FSM states:
  - IDLE: wait for the first rising edge, then go to MEAS. No result is produced for the partial period before it.
  - MEAS: on a rising edge, if the divider is idle, latch hi=hi_cnt and per=per_cnt into the divider, start it, and go to DIV.
  - DIV: counters keep running for the next period. On divider done: dutycycle_o = quotient, period_o = per, valid_o = 1 for one cycle, return to MEAS.
  - Rising edge while in DIV: discard that period, pulse overrun_o, counters restart as normal, stay in DIV.
- Arithmetic:
  - duty = (hi*100 + per/2) / per, i.e. round half up.
  - Numerator width CNT_W+7. Result clamped to 100.
  - per is never 0 when a division starts.
- Latency: valid_o rises exactly CNT_W+8 cycles after the cycle in which the closing rising edge is detected on s_pwm.
- Timeout: per_cnt reaching PERIOD_MAX with no rising edge means the input is constant.
  - Then: dutycycle_o = s_pwm ? 100 : 0, period_o = 0, valid_o pulses, counters clear, FSM goes to IDLE.
  - Timeout repeats every PERIOD_MAX cycles while the level stays constant.
  - A timeout during DIV aborts the division (no overrun pulse).
- valid_o and overrun_o never assert in the same cycle. Timeout takes priority over divider done.
- Reset mid-measurement or mid-division drops all state. Outputs return to reset values immediately.

Optional Feature:
- Macro PWM_CAP_GLITCH_FILTER_EN.
- Defined:
  - Insert a filter after the synchronizer. The filtered level changes only after the synchronized input has held the new value for FILT_LEN consecutive cycles.
  - Pulses shorter than FILT_LEN are ignored.
  - Both edges are delayed equally, so the duty result is unchanged for clean inputs.
  - Latency to valid_o grows by FILT_LEN cycles.
- Undefined: s_pwm feeds the edge detector directly, and FILT_LEN is unused.

Decomposition:
- Package pwm_pkg holds:
  - DUTY_W = 7 and DUTY_MAX = 100, shared with the generator.
  - typedef duty_t = logic [DUTY_W-1:0].
  - typedef enum cap_state_e {IDLE, MEAS, DIV}.
- Sub-module pwm_div: parameterized restoring divider with start/done and fixed latency CNT_W+7 cycles. It computes the rounded numerator, the quotient and the clamp.

Test Plan:
- PERIOD_MAX=5000; pwm_i period 1000 cycles, high 250 -> after the 2nd rising edge: valid_o, dutycycle_o=25, period_o=1000, repeating every 1000 cycles.
- Period 1000, high 335 -> 34 (round half up). High 334 -> 33. High 999 -> 100. High 1 -> 0.
- pwm_i held 0 for 12000 cycles -> valid_o with dutycycle_o=0, period_o=0 at 5000 and 10000 cycles after the last edge. Held 1 -> dutycycle_o=100.
- Period 10 cycles (shorter than the divide latency) -> overrun_o pulses on every edge that arrives during DIV, and only quotients of completed divisions appear on valid_o.
- rstn_i asserted 400 cycles into a 1000-cycle period -> all outputs 0 at once. After release, first valid_o only after two new rising edges.
- With PWM_CAP_GLITCH_FILTER_EN: 2-cycle high glitches injected into a 25% waveform -> dutycycle_o stays 25 and no spurious period is measured.
